func_unit_pipe: RTL
===================

FUNC_UNIT_PIPE -- requirements
Module: func_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits, legal range 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  unit can accept; the transfer happens when in_valid && in_ready at a rising edge.
REQ-007 A, B  in  WIDTH  operands.
REQ-008 FS  in  5  function select.
REQ-009 SH  in  SHW  shift/rotate amount.
REQ-010 out_valid  out  1  result registers hold an unconsumed result.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 F  out  WIDTH  registered result.
REQ-013 C, V, N, Z  out  1 each  registered flags for F.
REQ-014 busy  out  1  multiply in progress.

Function
REQ-015 FS map (other codes pass A through, with flags as for transfer):
- 0, 7: transfer A
- 1: A+1
- 2: A+B
- 3: A+B+Cst
- 4: A+~B
- 5: A-B
- 6: A-1
- 8: AND
- 10: OR
- 12: XOR
- 14: ~A
- 16: LSL
- 17: LSR
- 18: ASR
- 19: ROR
- 20: MUL, low WIDTH bits of the product
REQ-016 Cst is an internal carry register; it SHALL take the C flag of every result at the edge that result is loaded.
REQ-017 Arithmetic flags:
- C = carry out of the WIDTH-bit add; subtract is computed as A+~B+1.
- V = two's-complement overflow.
- Logic ops and transfer: C=0, V=0.
REQ-018 Shift and rotate flags:
- C = last bit shifted out; SH=0 gives C=0.
- V=0.
REQ-019 For every op: N=F[WIDTH-1]; Z=(F==0).
REQ-020 Single-cycle ops (all except MUL) SHALL have latency 1: accepted at edge k, so out_valid=1 and F and the flags are valid after edge k.
REQ-021 MUL SHALL be iterative shift-add, one bit per cycle.
- busy=1 from the accept edge until the result loads.
- The result loads, with out_valid=1, on the WIDTH-th edge after the accept edge.
- Flags: C=0, V=0.
REQ-022 in_ready = !busy && (!out_valid || out_ready); this allows back-to-back single-cycle ops with no bubble.
REQ-023 While out_valid && !out_ready, F, the flags and out_valid SHALL hold stable.
REQ-024 out_valid clears on an out_ready edge unless a new result loads on the same edge; a new load takes precedence.
REQ-025 A MUL that completes while the previous result is unconsumed SHALL wait, holding busy=1, until out_ready; no result is dropped.
REQ-026 Operand and FS values on the inputs while not transferring SHALL have no effect.

Reset
REQ-027 rst_n low SHALL asynchronously clear F, C, V, N, Z, Cst, out_valid, busy and the multiply state to 0.
REQ-028 Reset during a MUL SHALL abort it with no result produced.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n rises.

Structure
REQ-030 Shared package func_unit_pkg SHALL hold:
- FS opcode constants
- the flag-group typedef {C,V,N,Z}
REQ-031 Sub-module func_unit_mul_iter SHALL implement the iterative multiplier with a start/done handshake.
REQ-032 All other ops SHALL be combinational logic feeding the output registers in func_unit_pipe.

Verification (WIDTH=32)
REQ-033 A=FFFF_FFFF, FS=1 -> F=0000_0000, C=1, Z=1, V=0, N=0.
REQ-034 A=B=AAAA_5555:
- FS=2 -> F=5554_AAAA, C=1, V=1.
- Then FS=3 with the same operands -> F=5554_AAAB.
- Then FS=5 -> F=0, Z=1, C=1.
REQ-035 A=FFFF_FFFF, SH=31:
- FS=16 -> F=8000_0000, C=1.
- FS=17 -> F=0000_0001, C=1.
- FS=18 -> F=FFFF_FFFF.
- FS=19 with SH=4, A=1234_5678 -> F=8123_4567.
REQ-036 A=0001_0003, B=0000_0005, FS=20:
- busy=1 and in_ready=0 for 32 cycles.
- Then F=0005_000F, C=V=0.
- With out_ready held low 3 cycles, F and out_valid stay stable.
REQ-037 Back-to-back single-cycle ops with out_ready=1 -> one result per cycle, with in_ready never low.
REQ-038 rst_n pulsed low during cycle 10 of a MUL:
- Immediately: F=0, out_valid=0, busy=0.
- Then ADDC with A=B=1 -> F=2, confirming Cst was cleared.

Source files
------------

// File: rtl/func_unit_pkg.sv
// Shared definitions for the pipelined function unit: opcodes, flag group,
// multiplier state encoding and a flag-building helper.
package func_unit_pkg;

    localparam logic [4:0] FS_TA    = 5'd0;
    localparam logic [4:0] FS_INC   = 5'd1;
    localparam logic [4:0] FS_ADD   = 5'd2;
    localparam logic [4:0] FS_ADDC  = 5'd3;
    localparam logic [4:0] FS_ADDNB = 5'd4;
    localparam logic [4:0] FS_SUB   = 5'd5;
    localparam logic [4:0] FS_DEC   = 5'd6;
    localparam logic [4:0] FS_TA7   = 5'd7;
    localparam logic [4:0] FS_AND   = 5'd8;
    localparam logic [4:0] FS_OR    = 5'd10;
    localparam logic [4:0] FS_XOR   = 5'd12;
    localparam logic [4:0] FS_NOT   = 5'd14;
    localparam logic [4:0] FS_LSL   = 5'd16;
    localparam logic [4:0] FS_LSR   = 5'd17;
    localparam logic [4:0] FS_ASR   = 5'd18;
    localparam logic [4:0] FS_ROR   = 5'd19;
    localparam logic [4:0] FS_MUL   = 5'd20;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } flags_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // Assemble a flag group from carry, overflow, result sign and zero test.
    function automatic flags_t make_flags(input logic c, input logic v,
                                          input logic msb, input logic is_zero);
        flags_t f;
        f.c = c;
        f.v = v;
        f.n = msb;
        f.z = is_zero;
        return f;
    endfunction

endpackage

// File: rtl/func_unit_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of A*B.
// The first partial product is folded in on the start edge, so the product
// is complete WIDTH-1 edges later; it is then held until acknowledged.
module func_unit_mul_iter
    import func_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ack,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mul_state_t       state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [CW-1:0]    cnt_r;

    // Multiplier sequencer: load, one multiplier bit per edge, hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= MUL_IDLE;
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                MUL_IDLE: begin
                    if (start) begin
                        acc_r    <= b[0] ? a : {WIDTH{1'b0}};
                        mcand_r  <= {a[WIDTH-2:0], 1'b0};
                        mplier_r <= {1'b0, b[WIDTH-1:1]};
                        cnt_r    <= CW'(1);
                        state_r  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST_STEP) begin
                        state_r <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (ack) begin
                        state_r <= MUL_IDLE;
                    end
                end
                default: begin
                    state_r <= MUL_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_r != MUL_IDLE);
    assign done    = (state_r == MUL_DONE);
    assign product = acc_r;

endmodule

// File: rtl/func_unit_pipe.sv
// Function unit with valid/ready handshake: single-cycle ALU/shift ops load the
// result registers on the accept edge; MUL runs in an iterative sub-unit.
module func_unit_pipe
    import func_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FS,
    input  logic [SHW-1:0]   SH,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z,
    output logic             busy
);

    logic [WIDTH-1:0]   f_r;
    flags_t             flags_r;
    logic               cst_r;
    logic               out_valid_r;

    logic [WIDTH-1:0]   op_b_s;
    logic               cin_s;
    logic [WIDTH:0]     sum_s;
    logic               add_v_s;
    logic [WIDTH:0]     lsl_s;
    logic [WIDTH:0]     lsr_s;
    logic [WIDTH:0]     asr_s;
    logic [2*WIDTH-1:0] ror_s;
    logic [WIDTH-1:0]   res_s;
    logic               c_s;
    logic               v_s;
    flags_t             alu_flags_s;
    flags_t             mul_flags_s;
    logic               accept_s;
    logic               mul_start_s;
    logic               alu_load_s;
    logic               mul_load_s;
    logic               mul_busy_s;
    logic               mul_done_s;
    logic [WIDTH-1:0]   mul_product_s;

    // Second adder operand and carry-in; subtracts use A + ~B + 1.
    always_comb begin
        op_b_s = B;
        cin_s  = 1'b0;
        case (FS)
            FS_INC:   begin op_b_s = {WIDTH{1'b0}};               cin_s = 1'b1;  end
            FS_ADD:   begin op_b_s = B;                           cin_s = 1'b0;  end
            FS_ADDC:  begin op_b_s = B;                           cin_s = cst_r; end
            FS_ADDNB: begin op_b_s = ~B;                          cin_s = 1'b0;  end
            FS_SUB:   begin op_b_s = ~B;                          cin_s = 1'b1;  end
            FS_DEC:   begin op_b_s = {{(WIDTH-1){1'b1}}, 1'b0};  cin_s = 1'b1;  end
            default:  begin op_b_s = B;                           cin_s = 1'b0;  end
        endcase
    end

    assign sum_s   = {1'b0, A} + {1'b0, op_b_s} + {{WIDTH{1'b0}}, cin_s};
    assign add_v_s = (A[WIDTH-1] == op_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);

    // Shifts carry an extra bit so the last bit shifted out lands in a fixed slot.
    assign lsl_s = {1'b0, A} << SH;
    assign lsr_s = {A, 1'b0} >> SH;
    assign asr_s = $signed({A, 1'b0}) >>> SH;
    assign ror_s = {A, A} >> SH;

    // Single-cycle result and raw carry/overflow selection.
    always_comb begin
        res_s = A;
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (FS)
            FS_INC, FS_ADD, FS_ADDC, FS_ADDNB, FS_SUB, FS_DEC: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = add_v_s;
            end
            FS_AND: res_s = A & B;
            FS_OR:  res_s = A | B;
            FS_XOR: res_s = A ^ B;
            FS_NOT: res_s = ~A;
            FS_LSL: begin
                res_s = lsl_s[WIDTH-1:0];
                c_s   = lsl_s[WIDTH];
            end
            FS_LSR: begin
                res_s = lsr_s[WIDTH:1];
                c_s   = lsr_s[0];
            end
            FS_ASR: begin
                res_s = asr_s[WIDTH:1];
                c_s   = asr_s[0];
            end
            FS_ROR: begin
                res_s = ror_s[WIDTH-1:0];
                if (SH != {SHW{1'b0}}) begin
                    c_s = ror_s[WIDTH-1];
                end else begin
                    c_s = 1'b0;
                end
            end
            default: res_s = A;
        endcase
    end

    assign alu_flags_s = make_flags(c_s, v_s, res_s[WIDTH-1], res_s == {WIDTH{1'b0}});
    assign mul_flags_s = make_flags(1'b0, 1'b0, mul_product_s[WIDTH-1],
                                    mul_product_s == {WIDTH{1'b0}});

    assign in_ready    = !mul_busy_s && (!out_valid_r || out_ready);
    assign accept_s    = in_valid && in_ready;
    assign mul_start_s = accept_s && (FS == FS_MUL);
    assign alu_load_s  = accept_s && (FS != FS_MUL);
    assign mul_load_s  = mul_done_s && (!out_valid_r || out_ready);

    func_unit_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .ack     (mul_load_s),
        .a       (A),
        .b       (B),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Result registers: a new load wins over consumption; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_r         <= {WIDTH{1'b0}};
            flags_r     <= '{c: 1'b0, v: 1'b0, n: 1'b0, z: 1'b0};
            cst_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (alu_load_s) begin
            f_r         <= res_s;
            flags_r     <= alu_flags_s;
            cst_r       <= alu_flags_s.c;
            out_valid_r <= 1'b1;
        end else if (mul_load_s) begin
            f_r         <= mul_product_s;
            flags_r     <= mul_flags_s;
            cst_r       <= mul_flags_s.c;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign F         = f_r;
    assign C         = flags_r.c;
    assign V         = flags_r.v;
    assign N         = flags_r.n;
    assign Z         = flags_r.z;
    assign out_valid = out_valid_r;
    assign busy      = mul_busy_s;

endmodule
